// File: rtl/reg_file.sv
// Parameterised register file: one write port, two registered read ports with
// optional same-cycle write forwarding, synchronous clear and per-entry valid flags.
module reg_file #(
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             clr,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_a_n,
  output logic [WIDTH-1:0] rdata_b,
  output logic [WIDTH-1:0] rdata_b_n,
  output logic [DEPTH-1:0] valid
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_rdata_a;
  logic [WIDTH-1:0] r_rdata_a_n;
  logic [WIDTH-1:0] r_rdata_b;
  logic [WIDTH-1:0] r_rdata_b_n;

  logic             w_wr_hit;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  assign w_wr_hit = we && (32'(waddr) < DEPTH);

  // Read data as seen after this edge: clear applies first, then the write may forward.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    if (32'(raddr_a) < DEPTH) begin
      if ((BYPASS != 0) && w_wr_hit && (raddr_a == waddr)) begin
        w_rd_a = wdata;
      end else if (!clr) begin
        w_rd_a = r_mem[raddr_a];
      end
    end
    if (32'(raddr_b) < DEPTH) begin
      if ((BYPASS != 0) && w_wr_hit && (raddr_b == waddr)) begin
        w_rd_b = wdata;
      end else if (!clr) begin
        w_rd_b = r_mem[raddr_b];
      end
    end
  end

  // Storage and valid flags; a write on the clear edge survives the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_valid <= '0;
    end else begin
      if (clr) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          r_mem[i] <= '0;
        end
        r_valid <= '0;
      end
      if (w_wr_hit) begin
        r_mem[waddr]   <= wdata;
        r_valid[waddr] <= 1'b1;
      end
    end
  end

  // Complements are registered alongside the data so they track it through reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata_a   <= '0;
      r_rdata_a_n <= '1;
      r_rdata_b   <= '0;
      r_rdata_b_n <= '1;
    end else begin
      r_rdata_a   <= w_rd_a;
      r_rdata_a_n <= ~w_rd_a;
      r_rdata_b   <= w_rd_b;
      r_rdata_b_n <= ~w_rd_b;
    end
  end

  assign rdata_a   = r_rdata_a;
  assign rdata_a_n = r_rdata_a_n;
  assign rdata_b   = r_rdata_b;
  assign rdata_b_n = r_rdata_b_n;
  assign valid     = r_valid;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: three instances (forwarding, no forwarding, DEPTH=3) share
// stimulus; a behavioural model is compared every cycle plus literal spot checks.
module tb_reg_file;

  typedef logic [8:0] ent_t;
  typedef ent_t arr_t [4];

  logic       clk = 1'b0;
  logic       reset, we, clr;
  logic [1:0] waddr, raddr_a, raddr_b;
  ent_t       wdata;

  ent_t       rda [3];
  ent_t       rdan[3];
  ent_t       rdb [3];
  ent_t       rdbn[3];
  logic [3:0] valid0, valid1;
  logic [2:0] valid2;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  reg_file #(.WIDTH(9), .DEPTH(4), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda[0]), .rdata_a_n(rdan[0]),
    .rdata_b(rdb[0]), .rdata_b_n(rdbn[0]), .valid(valid0));

  reg_file #(.WIDTH(9), .DEPTH(4), .BYPASS(0)) u_nobyp (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda[1]), .rdata_a_n(rdan[1]),
    .rdata_b(rdb[1]), .rdata_b_n(rdbn[1]), .valid(valid1));

  reg_file #(.WIDTH(9), .DEPTH(3), .BYPASS(1)) u_d3 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda[2]), .rdata_a_n(rdan[2]),
    .rdata_b(rdb[2]), .rdata_b_n(rdbn[2]), .valid(valid2));

  // Reference model: what each instance must hold / return, from the behavioural rules.
  int   dep[3] = '{4, 4, 3};
  bit   byp[3] = '{1'b1, 1'b0, 1'b1};
  arr_t m_mem[3];
  logic [3:0] m_valid[3];
  ent_t m_a[3];
  ent_t m_b[3];
  bit   m_live = 1'b0;

  function automatic ent_t model_read(input int d, input int ra, input arr_t post);
    if (ra >= dep[d]) return '0;
    if (byp[d] && we && (int'(waddr) == ra) && (int'(waddr) < dep[d])) return wdata;
    return post[ra];
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      arr_t post;
      if (reset) begin
        for (int e = 0; e < 4; e++) m_mem[d][e] = '0;
        m_valid[d] = '0;
        m_a[d] = '0;
        m_b[d] = '0;
      end else begin
        for (int e = 0; e < 4; e++) post[e] = clr ? ent_t'(0) : m_mem[d][e];
        if (clr) m_valid[d] = '0;
        m_a[d] = model_read(d, int'(raddr_a), post);
        m_b[d] = model_read(d, int'(raddr_b), post);
        m_mem[d] = post;
        if (we && (int'(waddr) < dep[d])) begin
          m_mem[d][waddr] = wdata;
          m_valid[d][waddr] = 1'b1;
        end
      end
    end
    if (reset) m_live = 1'b1;
  end

  task automatic chk(input string nm, input ent_t act, input ent_t exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (m_live) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("model_rdata_a[%0d]", d), rda[d], m_a[d]);
        chk($sformatf("model_rdata_a_n[%0d]", d), rdan[d], ~m_a[d]);
        chk($sformatf("model_rdata_b[%0d]", d), rdb[d], m_b[d]);
        chk($sformatf("model_rdata_b_n[%0d]", d), rdbn[d], ~m_b[d]);
      end
      chk("model_valid0", ent_t'(valid0), ent_t'(m_valid[0]));
      chk("model_valid1", ent_t'(valid1), ent_t'(m_valid[1]));
      chk("model_valid2", ent_t'(valid2), ent_t'(m_valid[2][2:0]));
    end
  end

  task automatic step(input logic i_rst, input logic i_we, input logic [1:0] i_wa,
                      input ent_t i_wd, input logic i_clr, input logic [1:0] i_ra,
                      input logic [1:0] i_rb);
    reset = i_rst; we = i_we; waddr = i_wa; wdata = i_wd; clr = i_clr;
    raddr_a = i_ra; raddr_b = i_rb;
    @(posedge clk);
    #2;
  endtask

  initial begin
    ent_t one;
    reset = 1'b1; we = 1'b0; clr = 1'b0; waddr = '0; wdata = '0;
    raddr_a = '0; raddr_b = '0;
    #2;
    step(1, 0, 0, 9'h000, 0, 0, 0);
    step(1, 0, 0, 9'h000, 0, 0, 0);
    chk("reset_rdata_a", rda[0], 9'h000);
    chk("reset_rdata_a_n", rdan[0], 9'h1FF);
    chk("reset_valid", ent_t'(valid0), 9'h000);

    // One-hot fill, then read back on port A.
    for (int i = 0; i < 4; i++) step(0, 1, 2'(i), ent_t'(1) << i, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 9'h000, 0, 2'(i), 0);
      one = ent_t'(1) << i;
      chk("onehot_rdata_a", rda[0], one);
      chk("onehot_rdata_a_n", rdan[0], ~one);
    end
    chk("onehot_valid", ent_t'(valid0), 9'h00F);

    // Read/write collision with and without forwarding.
    step(0, 1, 2, 9'h0AA, 0, 0, 0);
    step(0, 1, 2, 9'h155, 0, 2, 0);
    chk("collide_bypass", rda[0], 9'h155);
    chk("collide_nobypass", rda[1], 9'h0AA);
    step(0, 0, 0, 9'h000, 0, 2, 0);
    chk("collide_nobypass_next", rda[1], 9'h155);

    // Clear coinciding with a write.
    for (int i = 0; i < 4; i++) step(0, 1, 2'(i), 9'h1FF, 0, 0, 0);
    step(0, 1, 1, 9'h003, 1, 1, 0);
    chk("clrwr_valid", ent_t'(valid0), 9'h002);
    chk("clrwr_bypass_a", rda[0], 9'h003);
    chk("clrwr_cleared_b", rdb[0], 9'h000);
    chk("clrwr_nobypass_a", rda[1], 9'h000);
    step(0, 0, 0, 9'h000, 0, 2, 1);
    chk("clrwr_entry2", rda[0], 9'h000);
    chk("clrwr_entry1", rdb[0], 9'h003);
    step(0, 0, 0, 9'h000, 0, 3, 0);
    chk("clrwr_entry3", rda[0], 9'h000);

    // Out-of-range write and read on the DEPTH=3 instance.
    step(0, 1, 3, 9'h1FF, 0, 1, 3);
    chk("d3_oob_valid", ent_t'(valid2), 9'h002);
    chk("d3_oob_rdata_b", rdb[2], 9'h000);
    chk("d3_oob_rdata_b_n", rdbn[2], 9'h1FF);
    chk("d3_entry1", rda[2], 9'h003);

    // Two ports on different entries while entry 0 is written.
    step(0, 1, 1, 9'h011, 0, 0, 0);
    step(0, 1, 3, 9'h033, 0, 0, 0);
    step(0, 1, 0, 9'h007, 0, 1, 3);
    chk("indep_a", rda[0], 9'h011);
    chk("indep_b", rdb[0], 9'h033);
    step(0, 0, 0, 9'h000, 0, 0, 0);
    chk("indep_same_a", rda[0], 9'h007);
    chk("indep_same_b", rdb[0], 9'h007);

    // Reset wins over write and clear.
    step(1, 1, 0, 9'h055, 1, 0, 1);
    chk("midrst_rdata_a", rda[0], 9'h000);
    chk("midrst_rdata_b_n", rdbn[0], 9'h1FF);
    chk("midrst_valid", ent_t'(valid0), 9'h000);
    step(0, 1, 0, 9'h100, 0, 1, 1);
    step(0, 0, 0, 9'h000, 0, 0, 1);
    chk("postrst_entry0", rda[0], 9'h100);
    chk("postrst_entry1", rdb[0], 9'h000);

    // Mixed traffic checked by the model only.
    for (int k = 0; k < 200; k++) begin
      step(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
           ent_t'($urandom), ($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)));
    end
    step(0, 0, 0, 9'h000, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
